// File: rtl/adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package adder_pkg;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/full_adder.sv
// One combinational full-adder cell of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/ripple_adder_4bit.sv
// Registered ripple-carry adder: {cout, sum} = a + b + cin, one cycle latency.
// Define RIPPLE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module ripple_adder_4bit
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef RIPPLE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    // Carry is wired cell to cell; no lookahead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Registers only load on in_valid, so X on idle inputs never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (in_valid) begin
            sum  <= s;
            cout <= c[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_valid <= 1'b0;
        else        out_valid <= in_valid;
    end

`ifdef RIPPLE_ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ovf <= 1'b0;
        else if (in_valid) ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
`endif
endmodule

// File: tb/tb_ripple_adder_4bit.sv
// Self-checking bench for ripple_adder_4bit against an arithmetic reference model.
// Honours RIPPLE_ADDER_OVF_EN for the overflow output.
module tb_ripple_adder_4bit;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         out_valid;
`ifdef RIPPLE_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;
    logic         exp_vld  = 1'b0;
    logic         exp_ovf  = 1'b0;

    ripple_adder_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
`ifdef RIPPLE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".sum"}, {1'b0, sum}, {1'b0, exp_sum});
        chk({tag, ".cout"}, {{W{1'b0}}, cout}, {{W{1'b0}}, exp_cout});
        chk({tag, ".vld"}, {{W{1'b0}}, out_valid}, {{W{1'b0}}, exp_vld});
`ifdef RIPPLE_ADDER_OVF_EN
        chk({tag, ".ovf"}, {{W{1'b0}}, ovf}, {{W{1'b0}}, exp_ovf});
`endif
    endtask

    // Reference: unsigned add for {cout,sum}, signed range check for ovf.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mc, input logic mv);
        int ua, sa, sb, sr;
        exp_vld = mv;
        if (mv) begin
            ua = int'(ma) + int'(mb) + int'(mc);
            exp_sum  = W'(ua % (1 << W));
            exp_cout = (ua >= (1 << W));
            sa = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
            sb = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
            sr = sa + sb + int'(mc);
            exp_ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        end
    endtask

    task automatic apply(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic vv);
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = vv;
        @(posedge clk);
        model(va, vb, vc, vv);
        #1;
        chk_all(tag);
    endtask

    initial begin
        #3;
        chk_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        apply("nonzero", 4'b1111, 4'b1111, 1'b1, 1'b1);
        // Asynchronous reset mid-cycle, no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        exp_sum = '0; exp_cout = 1'b0; exp_vld = 1'b0; exp_ovf = 1'b0;
        chk_all("async_rst");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        apply("1+3",    4'b0001, 4'b0011, 1'b0, 1'b1);
        apply("a+6",    4'b1010, 4'b0110, 1'b0, 1'b1);
        apply("f+f+1",  4'b1111, 4'b1111, 1'b1, 1'b1);
        apply("f+0+1",  4'b1111, 4'b0000, 1'b1, 1'b1);
        apply("0+0+0",  4'b0000, 4'b0000, 1'b0, 1'b1);
        apply("7+5",    4'b0111, 4'b0101, 1'b1, 1'b1);
        apply("hold",   4'b1001, 4'b1100, 1'b1, 1'b0);
        apply("hold_x", 'x, 'x, 1'bx, 1'b0);
        apply("7+1",    4'b0111, 4'b0001, 1'b0, 1'b1);
        apply("8+8",    4'b1000, 4'b1000, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++)
            apply("b2b", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 40; i++)
            apply("rand", W'($urandom), W'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ripple_adder_4bit.md
Name: ripple_adder_4bit

Overview:
- Registered ripple-carry adder: computes a + b + cin through a chain of WIDTH full-adder cells.
- Captures the result into output registers one clock after a valid input.
- Used as the small-integer add stage in datapaths that need a clean registered sum and carry-out.
- Single clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  qualifies a, b, cin this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  registered sum bits [WIDTH-1:0].
- cout  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  high for one cycle when sum/cout hold a new result.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n = 0, sum = 0, cout = 0, out_valid = 0, immediately, with no clock needed.
- Arithmetic: {cout, sum} = a + b + cin, computed as a strict ripple chain.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i.
  - c_0 = cin; cout = c_WIDTH.
  - No carry-lookahead or tool "+" operator on the full vector.
- Operands are unsigned. The result is exact modulo 2^(WIDTH+1); no saturation.
- Latency: exactly 1 cycle.
  - in_valid = 1 at edge N: sum/cout update at edge N and out_valid = 1 after edge N.
- Hold: in_valid = 0 at an edge leaves sum/cout unchanged and drives out_valid to 0.
- Back-to-back: in_valid high on consecutive cycles gives one result per cycle. out_valid stays high.
- No backpressure: results are never stalled or dropped except by reset.
- Reset mid-operation: a result captured in the same cycle rst_n falls is discarded. Outputs read 0.
- After rst_n rises, the first valid input is processed normally on the next edge.
- Boundaries:
  - all-ones + all-ones + 1 gives sum = all-ones, cout = 1.
  - 0 + 0 + 0 gives sum = 0, cout = 0.
  - all-ones + 0 + 1 gives sum = 0, cout = 1 (full carry ripple).
- X on a/b/cin with in_valid = 0 must not propagate to the outputs.

Optional Feature:
- Macro: RIPPLE_ADDER_OVF_EN.
- With macro defined:
  - Adds output ovf (1 bit, registered, reset 0) = c_WIDTH ^ c_(WIDTH-1), the two's-complement signed overflow.
  - ovf updates under the same in_valid/latency rules as sum.
- Without macro: the port and its logic are absent; everything else is identical.

Decomposition:
- Package adder_pkg: localparam DEFAULT_WIDTH = 4.
- Sub-module full_adder (inputs a, b, ci; outputs s, co): purely combinational.
  - Instantiated WIDTH times via generate; carry wired cell to cell.
- Top level holds only the generate chain, the output registers and the valid register.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with outputs non-zero -> sum = 0000, cout = 0, out_valid = 0 without a clock edge.
- a = 0001, b = 0011, cin = 0, in_valid = 1 -> next edge sum = 0100, cout = 0, out_valid = 1.
- a = 1010, b = 0110, cin = 0 -> sum = 0000, cout = 1.
- a = 1111, b = 1111, cin = 1 -> sum = 1111, cout = 1. Then a = 1111, b = 0000, cin = 1 -> sum = 0000, cout = 1.
- Hold and random:
  - Drop in_valid and change a/b -> sum/cout hold, out_valid = 0.
  - Then 3 back-to-back random vectors -> each result matches a + b + cin one cycle later.
- With RIPPLE_ADDER_OVF_EN: a = 0111, b = 0001, cin = 0 -> sum = 1000, ovf = 1. a = 1000, b = 1000 -> sum = 0000, cout = 1, ovf = 1.
